// File: rtl/wdata_assemble.sv
// Assembles 20-bit channel words from two 16-bit DSP bus writes (low half, then high nibble).
// Latency: commit visible on the 3rd clk edge that samples wr_n low; upd is a one-cycle pulse.
// Backpressure: none; the DSP paces writes (>=4 clk low/high), short strobes may be lost.
module wdata_assemble #(
    parameter int NCH = 8,
    parameter int DW  = 20,
    parameter int BW  = 16,
    parameter int AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_n,
    input  logic [AW-1:0]     choice,
    input  logic [BW-1:0]     datain,
    input  logic              err_clr,
    output logic [NCH*DW-1:0] data_all,
    output logic [NCH-1:0]    upd,
    output logic              seq_err,
    output logic              addr_err
);

    localparam int HW = DW - BW;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic s1, s2, s3;
    logic wr_evt;

    logic [BW-1:0]  shadow_lo [NCH];
    logic [NCH-1:0] lo_valid;

    logic [AW-1:0]  choice_m1;
    logic [CW-1:0]  ch;
    logic           addr_ok;
    logic           lo_wr;
    logic           hi_wr;
    logic           hi_ok;
    logic           hi_bad;
    logic           addr_bad;

    // Three-flop synchronizer; the strobe is treated as a falling-edge event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= wr_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign wr_evt = s3 & ~s2;

    // Odd choices stage a low half, even choices commit; choice-1 maps both onto channel*2+half.
    always_comb begin
        addr_ok   = (choice != '0) && (32'(choice) <= 2 * NCH);
        choice_m1 = choice - AW'(1);
        ch        = choice_m1[CW:1];
        lo_wr     = wr_evt &  addr_ok & ~choice_m1[0];
        hi_wr     = wr_evt &  addr_ok &  choice_m1[0];
        hi_ok     = hi_wr &  lo_valid[ch];
        hi_bad    = hi_wr & ~lo_valid[ch];
        addr_bad  = wr_evt & ~addr_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_valid <= '0;
            for (int k = 0; k < NCH; k++) begin
                shadow_lo[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (lo_wr && (ch == CW'(k))) begin
                    shadow_lo[k] <= datain;
                    lo_valid[k]  <= 1'b1;
                end else if (hi_ok && (ch == CW'(k))) begin
                    lo_valid[k]  <= 1'b0;
                end
            end
        end
    end

    // All DW bits of a channel load on the same edge, so readers never see a half-written word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_all <= '0;
            upd      <= '0;
        end else begin
            upd <= '0;
            for (int k = 0; k < NCH; k++) begin
                if (hi_ok && (ch == CW'(k))) begin
                    data_all[k*DW +: DW] <= {datain[HW-1:0], shadow_lo[k]};
                    upd[k]               <= 1'b1;
                end
            end
        end
    end

    // Error set takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            seq_err  <= (seq_err  & ~err_clr) | hi_bad;
            addr_err <= (addr_err & ~err_clr) | addr_bad;
        end
    end

endmodule

// File: tb/tb_wdata_assemble.sv
// Randomized scoreboard bench for wdata_assemble against a word-level model of the channel registers.
module tb_wdata_assemble;
    localparam int NCH = 8;
    localparam int DW  = 20;
    localparam int BW  = 16;
    localparam int AW  = 5;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              wr_n    = 1'b1;
    logic              err_clr = 1'b0;
    logic [AW-1:0]     choice  = '0;
    logic [BW-1:0]     datain  = '0;
    logic [NCH*DW-1:0] data_all;
    logic [NCH-1:0]    upd;
    logic              seq_err;
    logic              addr_err;

    always #5 clk = ~clk;

    wdata_assemble #(.NCH(NCH), .DW(DW), .BW(BW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_n     (wr_n),
        .choice   (choice),
        .datain   (datain),
        .err_clr  (err_clr),
        .data_all (data_all),
        .upd      (upd),
        .seq_err  (seq_err),
        .addr_err (addr_err)
    );

    typedef struct packed {
        logic [NCH-1:0]    m;
        logic [NCH*DW-1:0] d;
    } ev_t;

    ev_t exp_q[$];

    logic [DW-1:0] m_chan [NCH];
    logic [BW-1:0] m_lo   [NCH];
    bit            m_lv   [NCH];
    bit            m_seq;
    bit            m_addr;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [NCH*DW-1:0] act, input logic [NCH*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH*DW-1:0] m_flat();
        logic [NCH*DW-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = m_chan[k];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            m_chan[k] = '0;
            m_lo[k]   = '0;
            m_lv[k]   = 1'b0;
        end
        m_seq  = 1'b0;
        m_addr = 1'b0;
    endtask

    task automatic model_write(input int c, input logic [BW-1:0] d, input bit clr);
        int k;
        if (clr) begin
            m_seq  = 1'b0;
            m_addr = 1'b0;
        end
        if (c == 0 || c > 2 * NCH) begin
            m_addr = 1'b1;
        end else if (c % 2 == 1) begin
            k = (c - 1) / 2;
            m_lo[k] = d;
            m_lv[k] = 1'b1;
        end else begin
            k = c / 2 - 1;
            if (m_lv[k]) begin
                m_chan[k] = {d[3:0], m_lo[k]};
                m_lv[k]   = 1'b0;
                exp_q.push_back('{m: NCH'(1) << k, d: m_flat()});
            end else begin
                m_seq = 1'b1;
            end
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_data_all"}, data_all, m_flat());
        chk({tag, "_seq_err"}, {{(NCH*DW-1){1'b0}}, seq_err}, {{(NCH*DW-1){1'b0}}, m_seq});
        chk({tag, "_addr_err"}, {{(NCH*DW-1){1'b0}}, addr_err}, {{(NCH*DW-1){1'b0}}, m_addr});
    endtask

    // One full bus cycle; optionally pulse err_clr in the cycle the strobe is decoded.
    task automatic bus_write(input int c, input logic [BW-1:0] d, input bit clr_evt = 1'b0);
        @(negedge clk);
        choice = AW'(c);
        datain = d;
        model_write(c, d, clr_evt);
        @(negedge clk);
        wr_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            err_clr = (clr_evt && i == 2);
        end
        wr_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_state("after_write");
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_seq  = 1'b0;
        m_addr = 1'b0;
        @(negedge clk);
        chk_state("after_clr");
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("in_reset_upd", {{(NCH*DW-NCH){1'b0}}, upd}, '0);
        chk_state("in_reset");
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every upd pulse must match the next expected commit, at the required latency.
    int lat = 0;
    always @(posedge clk) lat <= wr_n ? 0 : lat + 1;

    logic [NCH*DW-1:0] prev_da = '0;
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (upd != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_upd", {{(NCH*DW-NCH){1'b0}}, upd}, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("upd_mask", {{(NCH*DW-NCH){1'b0}}, upd}, {{(NCH*DW-NCH){1'b0}}, e.m});
                    chk("upd_data", data_all, e.d);
                    chk("upd_latency", (NCH*DW)'(lat), (NCH*DW)'(3));
                end
            end else begin
                chk("stable_without_upd", data_all, prev_da);
            end
        end
        prev_da = data_all;
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_upd", {{(NCH*DW-NCH){1'b0}}, upd}, '0);
        chk_state("reset");
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_upd", {{(NCH*DW-NCH){1'b0}}, upd}, '0);
            chk_state("idle");
        end

        bus_write(5, 16'hBEEF);
        bus_write(6, 16'hFFF7);
        chk("ch2_commit", {{(NCH*DW-DW){1'b0}}, data_all[2*DW +: DW]}, {{(NCH*DW-DW){1'b0}}, 20'h7BEEF});

        bus_write(1, 16'hBCDE);
        bus_write(2, 16'h000A);
        bus_write(1, 16'h1234);
        chk("ch0_held", {{(NCH*DW-DW){1'b0}}, data_all[DW-1:0]}, {{(NCH*DW-DW){1'b0}}, 20'hABCDE});
        bus_write(2, 16'h0005);
        chk("ch0_commit", {{(NCH*DW-DW){1'b0}}, data_all[DW-1:0]}, {{(NCH*DW-DW){1'b0}}, 20'h51234});

        bus_write(16, 16'h0009);
        clr_pulse();
        bus_write(16, 16'h0009, 1'b1);

        bus_write(0, 16'h1111);
        bus_write(17, 16'h2222);
        bus_write(3, 16'h0001);
        bus_write(3, 16'h0002);
        bus_write(4, 16'h0003);
        chk("ch1_overwrite", {{(NCH*DW-DW){1'b0}}, data_all[DW +: DW]}, {{(NCH*DW-DW){1'b0}}, 20'h30002});

        bus_write(7, 16'h4444);
        do_reset(2);
        bus_write(8, 16'h0006);
        chk("ch3_after_reset", {{(NCH*DW-DW){1'b0}}, data_all[3*DW +: DW]}, '0);

        for (int n = 0; n < 120; n++) begin
            bus_write($urandom_range(0, 18), BW'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 15) == 0) clr_pulse();
        end

        repeat (4) @(negedge clk);
        chk("pending_commits", (NCH*DW)'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
